// File: rtl/vec_scale_pipe.sv
// vec_scale_pipe: two-stage fixed-point vector scaler, out[i] = (x[i]*a) >>> Q_BITS.
// FWFT FIFO on the input side, FIFO push on the output side, overflow counter.
module vec_scale_pipe #(
  parameter int LANES    = 3,
  parameter int DATA_W   = 32,
  parameter int Q_BITS   = 16,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [LANES-1:0][DATA_W-1:0]   x,
  input  logic [DATA_W-1:0]              a,
  input  logic                           in_empty,
  output logic                           in_rd_en,
  output logic [LANES-1:0][DATA_W-1:0]   out,
  input  logic                           out_full,
  output logic                           out_wr_en,
  input  logic                           ovf_clr,
  output logic [CNT_W-1:0]               ovf_count
);

  localparam int PW = 2 * DATA_W;
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0] RND =
    (ROUND != 0) ? (RW'(1) << (Q_BITS - 1)) : '0;
  localparam logic signed [RW-1:0] MAXV =
    (RW'(1) << (DATA_W - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV =
    -(RW'(1) << (DATA_W - 1));

  logic signed [PW-1:0]          r_p [LANES];
  logic                          r_s1_valid;
  logic                          r_s2_valid;
  logic                          r_s2_ovf;
  logic [LANES-1:0][DATA_W-1:0]  r_out;
  logic [CNT_W-1:0]              r_ovf_count;

  logic                          w_s1_ready;
  logic                          w_s2_ready;
  logic signed [PW-1:0]          w_prod [LANES];
  logic signed [RW-1:0]          w_r [LANES];
  logic [LANES-1:0][DATA_W-1:0]  w_res;
  logic                          w_ovf;

  assign w_s2_ready = !r_s2_valid || !out_full;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_rd_en   = !reset && !in_empty && w_s1_ready;
  assign out_wr_en  = r_s2_valid && !out_full;
  assign out        = r_out;
  assign ovf_count  = r_ovf_count;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = $signed({{DATA_W{x[i][DATA_W-1]}}, x[i]})
                * $signed({{DATA_W{a[DATA_W-1]}}, a});
    end
  end

  // One extra bit of headroom so the rounding add can never wrap.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      w_r[i] = ($signed({r_p[i][PW-1], r_p[i]}) + RND) >>> Q_BITS;
      if (w_r[i] > MAXV) begin
        w_ovf    = 1'b1;
        w_res[i] = (SATURATE != 0) ? MAXV[DATA_W-1:0]
                                   : w_r[i][DATA_W-1:0];
      end else if (w_r[i] < MINV) begin
        w_ovf    = 1'b1;
        w_res[i] = (SATURATE != 0) ? MINV[DATA_W-1:0]
                                   : w_r[i][DATA_W-1:0];
      end else begin
        w_res[i] = w_r[i][DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (in_rd_en) begin
      r_p <= w_prod;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_ovf    <= 1'b0;
      r_out       <= '0;
      r_ovf_count <= '0;
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= in_rd_en;
      end
      if (w_s2_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out    <= w_res;
          r_s2_ovf <= w_ovf;
        end
      end
      if (ovf_clr) begin
        r_ovf_count <= '0;
      end else if (out_wr_en && r_s2_ovf && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + CNT_W'(1);
      end
    end
  end

endmodule
